// File: rtl/anton_pkg.sv
// anton_pkg: shared FSM state enum and operand-pair struct for the anton feeder.
package anton_pkg;
  typedef enum logic [2:0] {INIT, IDLE, SEND_A, SEND_B, WAIT, HOLD} state_t;
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
  } pair_t;
endpackage

// File: rtl/anton_pair_fifo.sv
// anton_pair_fifo: first-in first-out buffer of operand pairs.
// Ports: clk, reset (async active-low), push/din enqueue, pop/dout dequeue
// (dout shows the head), full, empty.
module anton_pair_fifo
  import anton_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  pair_t din,
  input  logic  pop,
  output pair_t dout,
  output logic  full,
  output logic  empty
);
  localparam int AW = $clog2(DEPTH);
  pair_t mem [DEPTH];
  // one extra pointer bit tells full apart from empty
  logic [AW:0] wr, rd;
  assign empty = wr == rd;
  assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign dout = mem[rd[AW-1:0]];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push && !full) wr <= wr + (AW+1)'(1);
      if (pop && !empty) rd <= rd + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wr[AW-1:0]] <= din;
endmodule

// File: rtl/anton_feeder.sv
// anton_feeder: buffers operand pairs and feeds them nibble-serially to anton_product.
// Ports: clk, reset (async active-low); in_valid/in_ready/in_a/in_b pair input;
// prod_nibble/prod_read/prod_reset/prod_result multiplier side;
// out_data/out_valid/out_ready result output; op_count completed operations.
module anton_feeder
  import anton_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RESULT_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  output logic [3:0] prod_nibble,
  output logic       prod_read,
  output logic       prod_reset,
  input  logic [7:0] prod_result,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] op_count
);
  state_t state;
  pair_t head;
  logic full, empty, pop;
  logic [3:0] b_hold;
  logic [2:0] lat;
  // gated by reset so in_ready is low while held in reset
  assign in_ready = reset & ~full;
  assign pop = (state == IDLE) && !empty;
  anton_pair_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(in_valid & in_ready),
    .din(pair_t'({in_a, in_b})),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= INIT;
      b_hold <= '0;
      lat <= '0;
      prod_reset <= 1'b1;
      prod_read <= 1'b0;
      prod_nibble <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      op_count <= '0;
    end else
      case (state)
        INIT: begin
          prod_reset <= 1'b0;
          state <= IDLE;
        end
        IDLE: if (!empty) begin
          b_hold <= head.b;
          prod_nibble <= head.a;
          prod_read <= 1'b1;
          state <= SEND_A;
        end
        SEND_A: begin
          prod_nibble <= b_hold;
          state <= SEND_B;
        end
        SEND_B: begin
          prod_nibble <= '0;
          prod_read <= 1'b0;
          lat <= 3'(RESULT_LAT);
          state <= WAIT;
        end
        // the cycle that would take lat to zero is the capture cycle
        WAIT: if (lat == 3'd1) begin
          out_data <= prod_result;
          out_valid <= 1'b1;
          op_count <= op_count + 8'd1;
          state <= HOLD;
        end else lat <= lat - 3'd1;
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= INIT;
      endcase
endmodule

// File: tb/tb_anton_feeder.sv
// tb_anton_feeder: directed and randomized checks of anton_feeder against a product model and result queue.
module tb_anton_feeder;
  logic clk, reset, in_valid, in_ready, prod_read, prod_reset, out_valid, out_ready;
  logic [3:0] in_a, in_b, prod_nibble;
  logic [7:0] prod_result, out_data, op_count;
  int total = 0, bad = 0, rd_cnt = 0;
  bit stalled;
  logic [7:0] got[$], exp_q[$];
  logic [3:0] px;
  logic half;

  anton_feeder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .prod_nibble(prod_nibble), .prod_read(prod_read),
    .prod_reset(prod_reset), .prod_result(prod_result), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .op_count(op_count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // anton_product stand-in: two strobed nibbles, product one cycle after the second
  always @(posedge clk)
    if (prod_reset) begin
      half <= 0; px <= 0; prod_result <= 0;
    end else if (prod_read) begin
      if (!half) begin px <= prod_nibble; half <= 1; end
      else begin prod_result <= px * prod_nibble; half <= 0; end
    end

  always @(posedge clk) begin
    if (reset && out_valid && out_ready) got.push_back(out_data);
    if (reset && prod_read) rd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1; in_a = a; in_b = b;
    while (!in_ready && n < 200) begin
      stalled = 1;
      @(negedge clk);
      n++;
    end
    chk("send ready", 32'(in_ready), 1);
    exp_q.push_back(8'(a * b));
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic wait_got(input int target);
    int n = 0;
    while (got.size() < target && n < 3000) begin @(negedge clk); n++; end
    chk("result timeout", 32'(got.size() >= target), 1);
  endtask

  task automatic check_results(input int gb);
    chk("result count", 32'(got.size() - gb), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && gb + i < got.size(); i++)
      chk($sformatf("result %0d", i), 32'(got[gb+i]), 32'(exp_q[i]));
    exp_q.delete();
  endtask

  initial begin
    int gb, rb, n;
    reset = 0; in_valid = 0; in_a = 0; in_b = 0; out_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst in_ready", 32'(in_ready), 0);
    chk("rst prod_reset", 32'(prod_reset), 1);
    chk("rst prod_read", 32'(prod_read), 0);
    chk("rst nibble", 32'(prod_nibble), 0);
    chk("rst out", 32'({out_valid, out_data}), 0);
    chk("rst op_count", 32'(op_count), 0);
    reset = 1;
    #1;
    chk("init in_ready", 32'(in_ready), 1);
    chk("init prod_reset", 32'(prod_reset), 1);
    @(negedge clk);
    chk("idle prod_reset", 32'(prod_reset), 0);
    chk("idle outs", 32'({prod_read, prod_nibble, out_valid, out_data, op_count}), 0);

    // single pair 3*5
    gb = got.size();
    send(3, 5);
    n = 0;
    while (!prod_read && n < 50) begin @(negedge clk); n++; end
    chk("p2 read a", 32'({prod_read, prod_nibble}), 32'({1'b1, 4'd3}));
    @(negedge clk);
    chk("p2 read b", 32'({prod_read, prod_nibble}), 32'({1'b1, 4'd5}));
    @(negedge clk);
    chk("p2 wait idle bus", 32'({prod_read, prod_nibble}), 0);
    @(negedge clk);
    chk("p2 out", 32'({out_valid, out_data}), 32'({1'b1, 8'h0F}));
    chk("p2 op_count", 32'(op_count), 1);
    wait_got(gb + 1);
    check_results(gb);

    // burst of 6 back-to-back random pairs
    gb = got.size();
    stalled = 0;
    for (int i = 0; i < 6; i++) send(4'($urandom), 4'($urandom));
    chk("p3 in_ready dropped", 32'(stalled), 1);
    wait_got(gb + 6);
    check_results(gb);
    chk("p3 op_count", 32'(op_count), 7);

    // backpressure on 15*15 with a second pair waiting
    gb = got.size();
    out_ready = 0;
    send(15, 15);
    send(2, 7);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    rb = rd_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("p4 hold", 32'({out_valid, out_data, 1'b0, prod_read}), 32'({1'b1, 8'hE1, 2'b00}));
    end
    chk("p4 no read", 32'(rd_cnt - rb), 0);
    out_ready = 1;
    @(negedge clk);
    chk("p4 released", 32'(out_valid), 0);
    wait_got(gb + 2);
    check_results(gb);

    // reset during WAIT with three pairs still queued
    for (int i = 0; i < 4; i++) send(4'($urandom), 4'($urandom));
    chk("p5 in wait", 32'({prod_read, out_valid}), 0);
    reset = 0;
    #1;
    chk("p5 rst outs", 32'({in_ready, prod_reset, out_valid, op_count}), 32'({2'b01, 1'b0, 8'd0}));
    @(negedge clk);
    reset = 1;
    exp_q.delete();
    gb = got.size();
    rb = rd_cnt;
    repeat (30) @(negedge clk);
    chk("p5 no out", 32'(got.size() - gb), 0);
    chk("p5 no read", 32'(rd_cnt - rb), 0);
    chk("p5 op_count", 32'(op_count), 0);
    chk("p5 in_ready", 32'(in_ready), 1);

    // 256 operations wrap op_count
    gb = got.size();
    for (int i = 0; i < 256; i++) send(4'($urandom), 4'($urandom));
    wait_got(gb + 255);
    chk("p6 op_count 255", 32'(op_count), 255);
    wait_got(gb + 256);
    @(negedge clk);
    chk("p6 op_count wrap", 32'(op_count), 0);
    check_results(gb);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
